// File: rtl/mux_pkt_arb.sv
// mux_pkt_arb: packet-level round-robin arbiter for a 2:1 router output mux, with stall watchdog and per-port packet counters
module mux_pkt_arb #(
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            ivalid_0,
  input  logic [1:0]      itype_0,
  input  logic            ivalid_1,
  input  logic [1:0]      itype_1,
  input  logic            ordy,
  output logic [1:0]      sel,
  output logic            ack_0,
  output logic            ack_1,
  output logic            busy,
  output logic            err_timeout,
  output logic [CNTW-1:0] pkt_cnt_0,
  output logic [CNTW-1:0] pkt_cnt_1
);
  localparam int SW = $clog2(TIMEOUT);
  localparam logic [1:0] HEAD = 2'b01, TAIL = 2'b10;
  // state encoding doubles as the one-hot mux select
  typedef enum logic [1:0] {IDLE = 2'b00, LOCK0 = 2'b01, LOCK1 = 2'b10} state_t;
  state_t state, state_nx;
  logic last, last_nx, err_nx;
  logic [SW-1:0] stall, stall_nx;
  logic req_0, req_1, port, ack, fin, abort;
  always_comb begin
    req_0    = ivalid_0 && itype_0 == HEAD;
    req_1    = ivalid_1 && itype_1 == HEAD;
    port     = state == LOCK1;
    ack      = state != IDLE && (port ? ivalid_1 : ivalid_0) && ordy;
    fin      = ack && (port ? itype_1 : itype_0) == TAIL;
    abort    = state != IDLE && !ack && stall == SW'(TIMEOUT - 1);
    state_nx = state;
    last_nx  = last;
    err_nx   = 1'b0;
    stall_nx = '0;
    if (state == IDLE) begin
      if (req_0 && (!req_1 || last))
        state_nx = LOCK0;
      else if (req_1)
        state_nx = LOCK1;
    end else begin
      stall_nx = (ack || abort) ? '0 : stall + 1'b1;
      err_nx   = abort;
      if (fin || abort) begin
        state_nx = IDLE;
        last_nx  = port;
      end
    end
  end
  assign ack_0 = ack && !port;
  assign ack_1 = ack && port;
  assign sel   = state;
  assign busy  = state != IDLE;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state       <= IDLE;
      last        <= 1'b1;
      stall       <= '0;
      err_timeout <= 1'b0;
      pkt_cnt_0   <= '0;
      pkt_cnt_1   <= '0;
    end else begin
      state       <= state_nx;
      last        <= last_nx;
      stall       <= stall_nx;
      err_timeout <= err_nx;
      if (fin && !port) pkt_cnt_0 <= pkt_cnt_0 + 1'b1;
      if (fin && port)  pkt_cnt_1 <= pkt_cnt_1 + 1'b1;
    end
  end
endmodule
